game_round_sequencer: RTL and testbench
=======================================

Name: game_round_sequencer

Overview:
Multi-round sequencer for the Level 2/Level 3 game datapath. It drives the random number generator loads, timer load/enable, the player-load qualification and score clear. For each round it fires the RNGs, arms the countdown timer, and waits for a player entry or a timeout. It then samples the verifier result and counts hits until the configured number of rounds completes. It sits between the button shapers/access control and the RNG, digit timer and score modules.

Parameters:
ROUNDS, 5, rounds per game; legal 1..15
L2_TENS, 1, Level 2 timer tens digit (BCD)
L2_UNITS, 5, Level 2 timer units digit (BCD)
L3_TENS, 2, Level 3 timer tens digit (BCD)
L3_UNITS, 0, Level 3 timer units digit (BCD)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse from game button shaper
level_sel  in  2  2'b01 = Level 2, 2'b10 = Level 3, other values invalid
logged_in  in  1  high while user authenticated
abort  in  1  watchdog timeout or logout, level or pulse
player_load  in  1  one-cycle shaped player-entry pulse
timer_timeout  in  1  countdown reached 00
verify_ok  in  1  verifier result, valid the cycle after player_load_final
rng_load  out  1  RNG1 load pulse
rng2_load  out  1  RNG2 load pulse (Level 3 only)
timer_load  out  1  timer preset pulse
timer_enable  out  1  timer count enable
timer_tens  out  4  preset tens digit
timer_units  out  4  preset units digit
player_load_final  out  1  qualified player-load pulse to score/display registers
clear_score  out  1  score clear pulse
round_cnt  out  4  completed rounds
hits  out  4  verified-correct rounds
busy  out  1  game in progress
done  out  1  game complete, held

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched level cleared.
- Outputs are decoded from the registered state plus registered counters. Every pulse lasts exactly 1 cycle per state visit.
- States and transitions:
  - IDLE: busy=0. On start & logged_in & level_sel in {01,10}: latch level and go to CLEAR. Otherwise start is ignored.
  - CLEAR: clear_score=1; round_cnt<=0; hits<=0. Next state GEN.
  - GEN: rng_load=1; rng2_load=1 if latched level is L3. Next state ARM.
  - ARM: timer_load=1. timer_tens/units carry the level's digits; they hold these values through WAIT. Next state WAIT.
  - WAIT: timer_enable=1.
    - On player_load: go to LATCH.
    - Else on timer_timeout: go to NEXT as a miss.
    - If both occur in the same cycle, player_load wins.
  - LATCH: player_load_final=1; timer_enable=0. Next state CHECK.
  - CHECK: if verify_ok, hits<=hits+1. Next state NEXT.
  - NEXT: round_cnt<=round_cnt+1. If round_cnt+1==ROUNDS, go to DONE; else go to GEN.
  - DONE: done=1, busy=0; counters hold. start with a valid level (and logged_in) goes to CLEAR with the new level and drops done.
- busy=1 in every state except IDLE and DONE.
- Latency: start sampled in cycle 0 → clear_score in cycle 1, rng_load in cycle 2, timer_load in cycle 3, timer_enable from cycle 4.
- player_load outside WAIT is ignored; it never produces player_load_final.
- timer_timeout outside WAIT is ignored.
- start while busy is ignored.
- Abort rule: when abort=1 or logged_in=0, in any state, the next state is IDLE.
  - All outputs drop to 0 on that edge, and counters are cleared to 0.
  - Abort has priority over every other event in the same cycle.
- level_sel changes mid-game have no effect; the level latched at start is used until the next start.
- Counters never wrap, because ROUNDS ≤ 15 and hits ≤ round_cnt ≤ ROUNDS.

Test Plan:
- Reset then start with level_sel=01, ROUNDS=5. Each round: player_load 10 cycles after timer_enable, verify_ok=1 → per round: rng_load only, timer digits 1/5, player_load_final once. DONE after 5 rounds with round_cnt=5, hits=5, done=1, rng2_load never asserted.
- Level 3 with timer_timeout on every round → rng_load and rng2_load pulse together each round; digits 2/0; player_load_final never asserted; final hits=0, round_cnt=5.
- player_load and timer_timeout in the same WAIT cycle → LATCH path taken; one player_load_final; verify_ok=1 → hits increments by 1.
- abort pulse in WAIT of round 3 → next cycle IDLE; timer_enable=0, busy=0, round_cnt=0, hits=0; later player_load produces no player_load_final.
- start with level_sel=00 or 11, start with logged_in=0, and start while busy → no state change and no pulses. start in DONE with level_sel=10 → clear_score pulse, done=0, new game at Level 3.
- Async reset asserted mid-round, between clock edges → all outputs 0 immediately, without waiting for a clock edge; on release, stays IDLE until a valid start.

Source files
------------

// File: rtl/game_round_sequencer_if.sv
// Control bundle between the game sequencer and its surroundings:
// button shapers, access control, RNGs, digit timer and score registers.
interface game_round_sequencer_if;
  logic       start;
  logic [1:0] level_sel;
  logic       logged_in;
  logic       abort;
  logic       player_load;
  logic       timer_timeout;
  logic       verify_ok;
  logic       rng_load;
  logic       rng2_load;
  logic       timer_load;
  logic       timer_enable;
  logic [3:0] timer_tens;
  logic [3:0] timer_units;
  logic       player_load_final;
  logic       clear_score;
  logic [3:0] round_cnt;
  logic [3:0] hits;
  logic       busy;
  logic       done;

  modport slave (
    input  start, level_sel, logged_in, abort, player_load, timer_timeout, verify_ok,
    output rng_load, rng2_load, timer_load, timer_enable, timer_tens, timer_units,
           player_load_final, clear_score, round_cnt, hits, busy, done
  );

  modport master (
    output start, level_sel, logged_in, abort, player_load, timer_timeout, verify_ok,
    input  rng_load, rng2_load, timer_load, timer_enable, timer_tens, timer_units,
           player_load_final, clear_score, round_cnt, hits, busy, done
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Multi-round game sequencer: fires the RNGs, arms the countdown timer, waits
// for a player entry or timeout, samples the verifier and counts hits per game.
module game_round_sequencer #(
  parameter int ROUNDS   = 5,
  parameter int L2_TENS  = 1,
  parameter int L2_UNITS = 5,
  parameter int L3_TENS  = 2,
  parameter int L3_UNITS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  game_round_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CLEAR = 4'd1,
    S_GEN   = 4'd2,
    S_ARM   = 4'd3,
    S_WAIT  = 4'd4,
    S_LATCH = 4'd5,
    S_CHECK = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  localparam logic [3:0] ROUNDS_C   = 4'(ROUNDS);
  localparam logic [3:0] L2_TENS_C  = 4'(L2_TENS);
  localparam logic [3:0] L2_UNITS_C = 4'(L2_UNITS);
  localparam logic [3:0] L3_TENS_C  = 4'(L3_TENS);
  localparam logic [3:0] L3_UNITS_C = 4'(L3_UNITS);

  state_t     state_q, state_d;
  logic       level3_q, level3_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic [3:0] hits_q, hits_d;

  logic       rng_load_q, rng_load_d;
  logic       rng2_load_q, rng2_load_d;
  logic       timer_load_q, timer_load_d;
  logic       timer_enable_q, timer_enable_d;
  logic [3:0] timer_tens_q, timer_tens_d;
  logic [3:0] timer_units_q, timer_units_d;
  logic       player_load_final_q, player_load_final_d;
  logic       clear_score_q, clear_score_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic kill;
  logic level_valid;
  logic start_ok;

  // Losing the login is treated exactly like an abort, from any state.
  assign kill        = bus.abort | ~bus.logged_in;
  assign level_valid = (bus.level_sel == 2'b01) || (bus.level_sel == 2'b10);
  assign start_ok    = bus.start & bus.logged_in & level_valid;

  always_comb begin
    state_d     = state_q;
    level3_d    = level3_q;
    round_cnt_d = round_cnt_q;
    hits_d      = hits_q;
    if (kill) begin
      state_d     = S_IDLE;
      round_cnt_d = 4'd0;
      hits_d      = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            level3_d = (bus.level_sel == 2'b10);
            state_d  = S_CLEAR;
          end
        end
        S_CLEAR: begin
          round_cnt_d = 4'd0;
          hits_d      = 4'd0;
          state_d     = S_GEN;
        end
        S_GEN:   state_d = S_ARM;
        S_ARM:   state_d = S_WAIT;
        S_WAIT: begin
          // A player entry in the same cycle as the timeout still counts.
          if (bus.player_load) begin
            state_d = S_LATCH;
          end else if (bus.timer_timeout) begin
            state_d = S_NEXT;
          end
        end
        S_LATCH: state_d = S_CHECK;
        S_CHECK: begin
          if (bus.verify_ok) begin
            hits_d = hits_q + 4'd1;
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          round_cnt_d = round_cnt_q + 4'd1;
          state_d     = (round_cnt_q + 4'd1 == ROUNDS_C) ? S_DONE : S_GEN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // coincide with the state they belong to.
  always_comb begin
    rng_load_d          = (state_d == S_GEN);
    rng2_load_d         = (state_d == S_GEN) && level3_d;
    timer_load_d        = (state_d == S_ARM);
    timer_enable_d      = (state_d == S_WAIT);
    player_load_final_d = (state_d == S_LATCH);
    clear_score_d       = (state_d == S_CLEAR);
    busy_d              = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d              = (state_d == S_DONE);
    timer_tens_d        = 4'd0;
    timer_units_d       = 4'd0;
    if ((state_d == S_ARM) || (state_d == S_WAIT)) begin
      timer_tens_d  = level3_d ? L3_TENS_C  : L2_TENS_C;
      timer_units_d = level3_d ? L3_UNITS_C : L2_UNITS_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= S_IDLE;
      level3_q            <= 1'b0;
      round_cnt_q         <= 4'd0;
      hits_q              <= 4'd0;
      rng_load_q          <= 1'b0;
      rng2_load_q         <= 1'b0;
      timer_load_q        <= 1'b0;
      timer_enable_q      <= 1'b0;
      timer_tens_q        <= 4'd0;
      timer_units_q       <= 4'd0;
      player_load_final_q <= 1'b0;
      clear_score_q       <= 1'b0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      level3_q            <= level3_d;
      round_cnt_q         <= round_cnt_d;
      hits_q              <= hits_d;
      rng_load_q          <= rng_load_d;
      rng2_load_q         <= rng2_load_d;
      timer_load_q        <= timer_load_d;
      timer_enable_q      <= timer_enable_d;
      timer_tens_q        <= timer_tens_d;
      timer_units_q       <= timer_units_d;
      player_load_final_q <= player_load_final_d;
      clear_score_q       <= clear_score_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
    end
  end

  assign bus.rng_load          = rng_load_q;
  assign bus.rng2_load         = rng2_load_q;
  assign bus.timer_load        = timer_load_q;
  assign bus.timer_enable      = timer_enable_q;
  assign bus.timer_tens        = timer_tens_q;
  assign bus.timer_units       = timer_units_q;
  assign bus.player_load_final = player_load_final_q;
  assign bus.clear_score       = clear_score_q;
  assign bus.round_cnt         = round_cnt_q;
  assign bus.hits              = hits_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: directed scenarios plus a randomized run, all
// checked every cycle against a round-plan model of the game rules.
module tb_game_round_sequencer;

  localparam int ROUNDS = 5;
  localparam int L2T = 1, L2U = 5, L3T = 2, L3U = 0;

  // Phases of a round as the player experiences them.
  localparam int PH_CLR = 0, PH_GEN = 1, PH_ARM = 2, PH_WAIT = 3;
  localparam int PH_LATCH = 4, PH_CHECK = 5, PH_NEXT = 6;

  logic clk;
  logic rst;
  game_round_sequencer_if bus();

  game_round_sequencer #(
    .ROUNDS(ROUNDS), .L2_TENS(L2T), .L2_UNITS(L2U), .L3_TENS(L3T), .L3_UNITS(L3U)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a queue of upcoming round phases; an empty plan means not playing.
  int plan[$];
  int m_rounds, m_hits;
  bit m_done, m_l3;

  int cnt_rng, cnt_rng2, cnt_plf, cnt_clr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_rounds = 0;
    m_hits   = 0;
    m_done   = 0;
    m_l3     = 0;
  endtask

  task automatic model_step();
    int ph;
    if (bus.abort || !bus.logged_in) begin
      plan.delete();
      m_rounds = 0;
      m_hits   = 0;
      m_done   = 0;
    end else if (plan.size() == 0) begin
      if (bus.start && (bus.level_sel == 2'b01 || bus.level_sel == 2'b10)) begin
        m_l3   = (bus.level_sel == 2'b10);
        m_done = 0;
        plan   = '{PH_CLR, PH_GEN, PH_ARM, PH_WAIT};
      end
    end else begin
      ph = plan[0];
      case (ph)
        PH_CLR: begin
          m_rounds = 0;
          m_hits   = 0;
          void'(plan.pop_front());
        end
        PH_WAIT: begin
          if (bus.player_load) begin
            void'(plan.pop_front());
            plan.push_back(PH_LATCH);
            plan.push_back(PH_CHECK);
            plan.push_back(PH_NEXT);
          end else if (bus.timer_timeout) begin
            void'(plan.pop_front());
            plan.push_back(PH_NEXT);
          end
        end
        PH_CHECK: begin
          if (bus.verify_ok) m_hits++;
          void'(plan.pop_front());
        end
        PH_NEXT: begin
          m_rounds++;
          void'(plan.pop_front());
          if (m_rounds == ROUNDS) m_done = 1;
          else begin
            plan.push_back(PH_GEN);
            plan.push_back(PH_ARM);
            plan.push_back(PH_WAIT);
          end
        end
        default: void'(plan.pop_front());
      endcase
    end
  endtask

  task automatic check_outputs();
    int  ph;
    bit  digits;
    ph     = (plan.size() > 0) ? plan[0] : -1;
    digits = (ph == PH_ARM) || (ph == PH_WAIT);
    check_val("clear_score", bus.clear_score, ph == PH_CLR);
    check_val("rng_load", bus.rng_load, ph == PH_GEN);
    check_val("rng2_load", bus.rng2_load, (ph == PH_GEN) && m_l3);
    check_val("timer_load", bus.timer_load, ph == PH_ARM);
    check_val("timer_enable", bus.timer_enable, ph == PH_WAIT);
    check_val("timer_tens", bus.timer_tens, digits ? (m_l3 ? L3T : L2T) : 0);
    check_val("timer_units", bus.timer_units, digits ? (m_l3 ? L3U : L2U) : 0);
    check_val("player_load_final", bus.player_load_final, ph == PH_LATCH);
    check_val("round_cnt", bus.round_cnt, m_rounds);
    check_val("hits", bus.hits, m_hits);
    check_val("busy", bus.busy, plan.size() > 0);
    check_val("done", bus.done, m_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (bus.rng_load)          cnt_rng++;
    if (bus.rng2_load)         cnt_rng2++;
    if (bus.player_load_final) cnt_plf++;
    if (bus.clear_score)       cnt_clr++;
  endtask

  task automatic clear_counts();
    cnt_rng = 0; cnt_rng2 = 0; cnt_plf = 0; cnt_clr = 0;
  endtask

  task automatic start_game(input logic [1:0] lvl);
    bus.start     = 1'b1;
    bus.level_sel = lvl;
    cycle();
    bus.start     = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    int k = 0;
    while (!bus.timer_enable && k < 30) begin
      cycle();
      k++;
    end
    check_val(tag, bus.timer_enable, 1);
  endtask

  task automatic wait_idle_or_done(input string tag);
    int k = 0;
    while (bus.busy && k < 400) begin
      cycle();
      k++;
    end
    check_val(tag, bus.busy, 0);
  endtask

  initial begin
    bus.start = 0; bus.level_sel = 2'b00; bus.logged_in = 1; bus.abort = 0;
    bus.player_load = 0; bus.timer_timeout = 0; bus.verify_ok = 0;
    model_reset();
    clear_counts();
    rst = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle();

    // Level 2, every round answered correctly after 10 cycles of counting.
    $display("test: level 2 all hits");
    clear_counts();
    bus.verify_ok = 1'b1;
    start_game(2'b01);
    for (int r = 0; r < ROUNDS; r++) begin
      wait_enable("l2_wait_en");
      repeat (9) cycle();
      bus.player_load = 1'b1;
      cycle();
      bus.player_load = 1'b0;
    end
    wait_idle_or_done("l2_finish");
    check_val("l2_round_cnt", bus.round_cnt, 5);
    check_val("l2_hits", bus.hits, 5);
    check_val("l2_done", bus.done, 1);
    check_val("l2_rng_pulses", cnt_rng, 5);
    check_val("l2_rng2_pulses", cnt_rng2, 0);
    check_val("l2_plf_pulses", cnt_plf, 5);

    // Level 3, every round times out; restart straight from DONE.
    $display("test: level 3 all timeouts");
    clear_counts();
    start_game(2'b10);
    check_val("restart_clear", bus.clear_score, 1);
    check_val("restart_done", bus.done, 0);
    for (int r = 0; r < ROUNDS; r++) begin
      wait_enable("l3_wait_en");
      repeat (3) cycle();
      bus.timer_timeout = 1'b1;
      cycle();
      bus.timer_timeout = 1'b0;
    end
    wait_idle_or_done("l3_finish");
    check_val("l3_round_cnt", bus.round_cnt, 5);
    check_val("l3_hits", bus.hits, 0);
    check_val("l3_rng2_pulses", cnt_rng2, 5);
    check_val("l3_plf_pulses", cnt_plf, 0);

    // Simultaneous entry/timeout, then abort during round 3.
    $display("test: simultaneous events and abort");
    clear_counts();
    start_game(2'b01);
    bus.level_sel = 2'b10;
    for (int r = 0; r < 2; r++) begin
      wait_enable("sim_wait_en");
      bus.player_load = 1'b1;
      bus.timer_timeout = (r == 0);
      cycle();
      bus.player_load = 1'b0;
      bus.timer_timeout = 1'b0;
    end
    wait_enable("abort_wait_en");
    check_val("pre_abort_hits", bus.hits, 2);
    check_val("pre_abort_rng2", cnt_rng2, 0);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    check_val("abort_enable", bus.timer_enable, 0);
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_round_cnt", bus.round_cnt, 0);
    check_val("abort_hits", bus.hits, 0);
    cnt_plf = 0;
    bus.player_load = 1'b1;
    cycle();
    bus.player_load = 1'b0;
    repeat (2) cycle();
    check_val("abort_no_plf", cnt_plf, 0);

    // Starts that must be ignored.
    $display("test: ignored starts");
    clear_counts();
    start_game(2'b00);
    start_game(2'b11);
    bus.logged_in = 1'b0;
    start_game(2'b01);
    bus.logged_in = 1'b1;
    cycle();
    check_val("bad_start_clr", cnt_clr, 0);
    start_game(2'b01);
    repeat (3) cycle();
    start_game(2'b10);
    bus.timer_timeout = 1'b1;
    wait_idle_or_done("busy_start_finish");
    bus.timer_timeout = 1'b0;
    check_val("busy_start_clr", cnt_clr, 1);
    check_val("busy_start_rng2", cnt_rng2, 0);

    // Asynchronous reset between clock edges.
    $display("test: async reset mid-round");
    start_game(2'b10);
    wait_enable("rst_wait_en");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_val("arst_enable", bus.timer_enable, 0);
    check_val("arst_busy", bus.busy, 0);
    check_val("arst_tens", bus.timer_tens, 0);
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cycle();

    // Randomized traffic.
    $display("test: random");
    for (int i = 0; i < 4000; i++) begin
      bus.start         = ($urandom_range(0, 99) < 5);
      bus.level_sel     = 2'($urandom_range(0, 3));
      bus.logged_in     = ($urandom_range(0, 999) >= 3);
      bus.abort         = ($urandom_range(0, 999) < 3);
      bus.player_load   = ($urandom_range(0, 99) < 10);
      bus.timer_timeout = ($urandom_range(0, 99) < 8);
      bus.verify_ok     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
